mor1kx_cache_refill_wb: RTL and testbench
=========================================

Name: mor1kx_cache_refill_wb

Overview:
Wishbone B3 burst master that services cache line refills. It sits between the instruction cache and the bus. When the cache raises a refill request, the block runs a critical-word-first wrapping burst for one line. Each returned word goes back to the cache as a write strobe (wradr/wrdat/we), and bus errors are reported back to the cache.

Parameters:
OPTION_OPERAND_WIDTH, 32, data/address width; only 32 is supported.
OPTION_ICACHE_BLOCK_WIDTH, 5, log2 of line size in bytes; legal values are 4 (4 beats) and 5 (8 beats).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
refill_req_i  in  1  cache requests a line refill; held high until the cache leaves refill
refill_adr_i  in  32  miss address, critical word; sampled when the request is accepted
wradr_o  out  32  address of the word being written to the cache
wrdat_o  out  32  refill data word
we_o  out  1  single-cycle write strobe to the cache
refill_err_o  out  1  single-cycle bus error pulse to the cache
busy_o  out  1  high in any state other than IDLE
wbm_adr_o  out  32  bus address, word aligned
wbm_stb_o  out  1  strobe
wbm_cyc_o  out  1  cycle
wbm_cti_o  out  3  cycle type identifier
wbm_bte_o  out  2  burst type extension
wbm_sel_o  out  4  byte select; constant 4'hf
wbm_we_o  out  1  write enable; constant 0
wbm_ack_i  in  1  acknowledge
wbm_err_i  in  1  error
wbm_dat_i  in  32  read data

Behaviour:
- All outputs are registered, except the constants wbm_sel_o and wbm_we_o.
- Reset values: cyc=0, stb=0, we_o=0, refill_err_o=0, busy_o=0, cti=3'b000, bte=2'b00, wbm_adr_o=0, wradr_o=0, wrdat_o=0; state=IDLE.
- Reset is synchronous. Asserting it mid-burst drops cyc/stb at that edge; no we_o or err pulse is issued.
- BEATS = 1<<(OPTION_ICACHE_BLOCK_WIDTH-2). Beat counter width is OPTION_ICACHE_BLOCK_WIDTH-2 bits.
- States: IDLE, BURST, DONE.
- IDLE, on refill_req_i=1:
  - latch wbm_adr_o = {refill_adr_i[31:2], 2'b00};
  - set counter = BEATS-1;
  - set cyc = stb = 1, cti = 3'b010 (3'b111 if BEATS==1, which never occurs);
  - set bte = 2'b01 for 4 beats, 2'b10 for 8 beats;
  - go to BURST. Latency from request to stb is 1 cycle.
- BURST, on wbm_ack_i=1 and wbm_err_i=0:
  - next cycle: we_o=1, wrdat_o=wbm_dat_i, wradr_o=current wbm_adr_o;
  - wbm_adr_o[BLOCK_WIDTH-1:2] increments modulo BEATS (wraps inside the line); upper bits are unchanged;
  - counter decrements;
  - when the new counter value is 0, cti becomes 3'b111 (end of burst).
- Acking the beat with counter==0:
  - cyc, stb drop next cycle; cti and bte return to 0;
  - the final we_o fires that same next cycle;
  - go to DONE.
- wbm_ack_i=0: hold address and strobes (wait states are unlimited).
- wbm_err_i=1 in BURST (err wins over a simultaneous ack):
  - next cycle: cyc=stb=0, refill_err_o=1 for one cycle, no we_o for that beat;
  - go to DONE.
- DONE: cyc=stb=0. Stay until refill_req_i=0, then go to IDLE. This prevents the stale request that is still high while the cache consumes the last write from restarting a burst.
- ack/err while stb=0 are ignored.
- refill_req_i is ignored outside IDLE. refill_adr_i is sampled only on acceptance.
- we_o is never high in two consecutive cycles unless acks arrive in consecutive cycles. Each ack gives exactly one we_o.
- Word order for a line refill, given the critical word index k: k, k+1, ..., wrapping modulo BEATS, BEATS words total.

Test Plan:
- 8-beat refill, adr=0x0000_1014, ack every cycle:
  - stb rises 1 cycle after req;
  - wbm_adr sequence 0x1014, 0x1018, 0x101c, 0x1000, 0x1004, 0x1008, 0x100c, 0x1010;
  - cti is 010 for 7 beats then 111; bte=10;
  - 8 we_o pulses with matching wradr_o and data; then DONE until req drops.
- BLOCK_WIDTH=4, adr=0x0000_200c, ack every other cycle:
  - addresses 0x200c, 0x2000, 0x2004, 0x2008; bte=01;
  - we_o pulses spaced 2 cycles, 4 total.
- Error on beat 3 of 8:
  - 2 we_o pulses, refill_err_o pulses once, cyc=0 the next cycle;
  - no further bus activity while req stays high;
  - a new req after req drops starts a fresh burst.
- ack and err asserted in the same cycle on beat 1 -> treated as error, no we_o, refill_err_o=1.
- Synchronous reset asserted during beat 4 -> cyc/stb/we_o/busy_o all 0 after that edge; state IDLE; a new request is accepted normally.
- Request held high for 3 cycles after the last we_o -> no second burst; IDLE is re-entered only after req=0.

Source files
------------

// File: rtl/mor1kx_cache_refill_wb.sv
// Wishbone B3 burst master for instruction-cache line refills.
// Runs one critical-word-first wrapping burst per request and streams each word back to the cache.
module mor1kx_cache_refill_wb #(
  parameter int OPTION_OPERAND_WIDTH      = 32,
  parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            refill_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
  output logic                            we_o,
  output logic                            refill_err_o,
  output logic                            busy_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
  output logic                            wbm_stb_o,
  output logic                            wbm_cyc_o,
  output logic [2:0]                      wbm_cti_o,
  output logic [1:0]                      wbm_bte_o,
  output logic [3:0]                      wbm_sel_o,
  output logic                            wbm_we_o,
  input  logic                            wbm_ack_i,
  input  logic                            wbm_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i
);

  localparam int W     = OPTION_OPERAND_WIDTH;
  localparam int BW    = OPTION_ICACHE_BLOCK_WIDTH;
  localparam int CW    = BW - 2;
  localparam int BEATS = 1 << CW;

  localparam logic [2:0] CTI_START = (BEATS == 1) ? 3'b111 : 3'b010;
  localparam logic [1:0] BTE_LINE  = (BEATS == 4)  ? 2'b01 :
                                     (BEATS == 8)  ? 2'b10 :
                                     (BEATS == 16) ? 2'b11 : 2'b00;

  // Bus handshake: a beat completes on any cycle where stb is high and the
  // slave raises ack or err; err takes priority; ack/err with stb low are ignored.
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [W-1:0]    adr_n, wradr_n, wrdat_n;
  logic            cyc_n, stb_n, we_n, err_n, busy_n;
  logic [2:0]      cti_n;
  logic [1:0]      bte_n;

  assign wbm_sel_o = 4'hf;
  assign wbm_we_o  = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      wbm_adr_o    <= '0;
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
      wbm_cti_o    <= 3'b000;
      wbm_bte_o    <= 2'b00;
      wradr_o      <= '0;
      wrdat_o      <= '0;
      we_o         <= 1'b0;
      refill_err_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      wbm_adr_o    <= adr_n;
      wbm_cyc_o    <= cyc_n;
      wbm_stb_o    <= stb_n;
      wbm_cti_o    <= cti_n;
      wbm_bte_o    <= bte_n;
      wradr_o      <= wradr_n;
      wrdat_o      <= wrdat_n;
      we_o         <= we_n;
      refill_err_o <= err_n;
      busy_o       <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    adr_n   = wbm_adr_o;
    cyc_n   = wbm_cyc_o;
    stb_n   = wbm_stb_o;
    cti_n   = wbm_cti_o;
    bte_n   = wbm_bte_o;
    wradr_n = wradr_o;
    wrdat_n = wrdat_o;
    we_n    = 1'b0;
    err_n   = 1'b0;

    case (state)
      IDLE: begin
        if (refill_req_i) begin
          adr_n   = refill_adr_i & ~W'(3);
          cnt_n   = CW'(BEATS - 1);
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          cti_n   = CTI_START;
          bte_n   = BTE_LINE;
          state_n = BURST;
        end
      end
      BURST: begin
        if (wbm_stb_o && wbm_err_i) begin
          cyc_n   = 1'b0;
          stb_n   = 1'b0;
          cti_n   = 3'b000;
          bte_n   = 2'b00;
          err_n   = 1'b1;
          state_n = DONE;
        end else if (wbm_stb_o && wbm_ack_i) begin
          we_n    = 1'b1;
          wrdat_n = wbm_dat_i;
          wradr_n = wbm_adr_o;
          // Only the word index moves, so the burst wraps inside the line.
          adr_n[BW-1:2] = wbm_adr_o[BW-1:2] + CW'(1);
          cnt_n   = cnt - CW'(1);
          if (cnt == '0) begin
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            cti_n   = 3'b000;
            bte_n   = 2'b00;
            state_n = DONE;
          end else if (cnt == CW'(1)) begin
            cti_n = 3'b111;
          end
        end
      end
      DONE: begin
        // The request is still high while the cache swallows the last word.
        if (!refill_req_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_mor1kx_cache_refill_wb.sv
// Directed bench for the refill master: an 8-beat instance and a 4-beat instance
// share clock and reset; written words are scored against expected queues.
module tb_mor1kx_cache_refill_wb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-beat instance
  logic        req8 = 1'b0, ack8 = 1'b0, berr8 = 1'b0;
  logic [31:0] radr8 = '0, dat8 = '0;
  logic [31:0] wradr8, wrdat8, adr8;
  logic        we8, rerr8, busy8, stb8, cyc8, bwe8;
  logic [2:0]  cti8;
  logic [1:0]  bte8;
  logic [3:0]  sel8;

  // 4-beat instance
  logic        req4 = 1'b0, ack4 = 1'b0, berr4 = 1'b0;
  logic [31:0] radr4 = '0, dat4 = '0;
  logic [31:0] wradr4, wrdat4, adr4;
  logic        we4, rerr4, busy4, stb4, cyc4, bwe4;
  logic [2:0]  cti4;
  logic [1:0]  bte4;
  logic [3:0]  sel4;

  mor1kx_cache_refill_wb #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(5)) d8 (
    .clk(clk), .rst(rst), .refill_req_i(req8), .refill_adr_i(radr8),
    .wradr_o(wradr8), .wrdat_o(wrdat8), .we_o(we8), .refill_err_o(rerr8), .busy_o(busy8),
    .wbm_adr_o(adr8), .wbm_stb_o(stb8), .wbm_cyc_o(cyc8), .wbm_cti_o(cti8), .wbm_bte_o(bte8),
    .wbm_sel_o(sel8), .wbm_we_o(bwe8), .wbm_ack_i(ack8), .wbm_err_i(berr8), .wbm_dat_i(dat8)
  );

  mor1kx_cache_refill_wb #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(4)) d4 (
    .clk(clk), .rst(rst), .refill_req_i(req4), .refill_adr_i(radr4),
    .wradr_o(wradr4), .wrdat_o(wrdat4), .we_o(we4), .refill_err_o(rerr4), .busy_o(busy4),
    .wbm_adr_o(adr4), .wbm_stb_o(stb4), .wbm_cyc_o(cyc4), .wbm_cti_o(cti4), .wbm_bte_o(bte4),
    .wbm_sel_o(sel4), .wbm_we_o(bwe4), .wbm_ack_i(ack4), .wbm_err_i(berr4), .wbm_dat_i(dat4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dat_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: {address, data} per expected cache write
  logic [63:0] exp8_q[$];
  logic [63:0] exp4_q[$];
  int          we4_times[$];
  int          we_cnt8  = 0;
  int          err_cnt8 = 0;
  int          cyc_no   = 0;
  logic [63:0] e8, e4;

  always @(posedge clk) cyc_no = cyc_no + 1;

  always @(negedge clk) begin
    if (we8) begin
      we_cnt8++;
      if (exp8_q.size() == 0) check("we8_unexpected", 1, 0);
      else begin
        e8 = exp8_q.pop_front();
        check("wradr8", wradr8, e8[63:32]);
        check("wrdat8", wrdat8, e8[31:0]);
      end
    end
    if (rerr8) err_cnt8++;
    if (we4) begin
      we4_times.push_back(cyc_no);
      if (exp4_q.size() == 0) check("we4_unexpected", 1, 0);
      else begin
        e4 = exp4_q.pop_front();
        check("wradr4", wradr4, e4[63:32]);
        check("wrdat4", wrdat4, e4[31:0]);
      end
    end
  end

  // Acks n beats of the 8-beat instance starting at beat 'first' of the line.
  task automatic beats8(input logic [31:0] line_adr, input int first, input int n);
    logic [2:0]  idx;
    logic [31:0] a;
    for (int i = first; i < first + n; i++) begin
      idx = line_adr[4:2] + i[2:0];
      a   = {line_adr[31:5], idx, 2'b00};
      check("b8_adr", adr8, a);
      exp8_q.push_back({a, dat_of(a)});
      ack8 = 1'b1;
      dat8 = dat_of(a);
      tick;
    end
    ack8 = 1'b0;
  endtask

  logic [31:0] t1_adr [8] = '{32'h1014, 32'h1018, 32'h101c, 32'h1000,
                               32'h1004, 32'h1008, 32'h100c, 32'h1010};
  logic [31:0] t2_adr [4] = '{32'h200c, 32'h2000, 32'h2004, 32'h2008};
  int wc;

  initial begin
    repeat (3) tick;
    check("rst_cyc8", cyc8, 0);
    check("rst_stb8", stb8, 0);
    check("rst_we8", we8, 0);
    check("rst_err8", rerr8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_cti8", cti8, 0);
    check("rst_bte8", bte8, 0);
    check("rst_adr8", adr8, 0);
    check("rst_wradr8", wradr8, 0);
    check("rst_wrdat8", wrdat8, 0);
    check("rst_cyc4", cyc4, 0);
    check("sel8", sel8, 4'hf);
    check("bwe8", bwe8, 0);
    rst = 1'b0;
    tick;

    // 4-beat line, ack every other cycle
    req4 = 1'b1; radr4 = 32'h200c;
    tick;
    check("t2_stb", stb4, 1);
    check("t2_bte", bte4, 2'b01);
    for (int i = 0; i < 4; i++) begin
      check("t2_adr", adr4, t2_adr[i]);
      check("t2_cti", cti4, (i == 3) ? 3'b111 : 3'b010);
      exp4_q.push_back({t2_adr[i], dat_of(t2_adr[i])});
      ack4 = 1'b1; dat4 = dat_of(t2_adr[i]);
      tick;
      ack4 = 1'b0;
      tick;
    end
    check("t2_cyc_end", cyc4, 0);
    check("t2_busy_done", busy4, 1);
    req4 = 1'b0;
    tick;
    check("t2_busy_idle", busy4, 0);
    check("t2_we_count", we4_times.size(), 4);
    for (int i = 1; i < we4_times.size(); i++)
      check("t2_we_spacing", we4_times[i] - we4_times[i-1], 2);
    check("t2_q_empty", exp4_q.size(), 0);

    // 8-beat line, critical word 0x1014, ack every cycle
    req8 = 1'b1; radr8 = 32'h1014;
    check("t1_stb_before", stb8, 0);
    tick;
    check("t1_stb", stb8, 1);
    check("t1_cyc", cyc8, 1);
    check("t1_busy", busy8, 1);
    check("t1_bte", bte8, 2'b10);
    for (int i = 0; i < 8; i++) begin
      check("t1_adr", adr8, t1_adr[i]);
      check("t1_cti", cti8, (i == 7) ? 3'b111 : 3'b010);
      exp8_q.push_back({t1_adr[i], dat_of(t1_adr[i])});
      ack8 = 1'b1; dat8 = dat_of(t1_adr[i]);
      tick;
    end
    ack8 = 1'b0;
    check("t1_cyc_end", cyc8, 0);
    check("t1_stb_end", stb8, 0);
    check("t1_cti_end", cti8, 0);
    check("t1_bte_end", bte8, 0);
    check("t1_last_we", we8, 1);
    repeat (3) begin
      tick;
      check("t1_hold_cyc", cyc8, 0);
      check("t1_hold_busy", busy8, 1);
    end
    check("t1_we_count", we_cnt8, 8);
    check("t1_q_empty", exp8_q.size(), 0);
    req8 = 1'b0;
    tick;
    check("t1_busy_idle", busy8, 0);

    // Error on beat 3
    wc = we_cnt8;
    req8 = 1'b1; radr8 = 32'h1000;
    tick;
    beats8(32'h1000, 0, 2);
    check("t3_adr_b3", adr8, 32'h1008);
    berr8 = 1'b1;
    tick;
    berr8 = 1'b0;
    check("t3_cyc", cyc8, 0);
    check("t3_stb", stb8, 0);
    check("t3_err", rerr8, 1);
    check("t3_we", we8, 0);
    tick;
    check("t3_err_pulse", rerr8, 0);
    repeat (3) begin
      tick;
      check("t3_hold_cyc", cyc8, 0);
    end
    check("t3_we_count", we_cnt8 - wc, 2);
    check("t3_err_count", err_cnt8, 1);
    req8 = 1'b0;
    tick;
    check("t3_busy_idle", busy8, 0);

    // Fresh request; ack+err together on beat 1
    req8 = 1'b1; radr8 = 32'h101c;
    tick;
    check("t4_stb", stb8, 1);
    check("t4_adr", adr8, 32'h101c);
    ack8 = 1'b1; berr8 = 1'b1; dat8 = 32'hdead_beef;
    tick;
    ack8 = 1'b0; berr8 = 1'b0;
    check("t4_err", rerr8, 1);
    check("t4_we", we8, 0);
    check("t4_cyc", cyc8, 0);
    tick;
    tick;
    check("t4_we_count", we_cnt8 - wc, 2);
    check("t4_err_count", err_cnt8, 2);
    req8 = 1'b0;
    tick;

    // Synchronous reset during beat 4
    wc = we_cnt8;
    req8 = 1'b1; radr8 = 32'h1008;
    tick;
    beats8(32'h1008, 0, 3);
    check("t5_adr_b4", adr8, 32'h1014);
    rst = 1'b1; ack8 = 1'b1; dat8 = dat_of(32'h1014); req8 = 1'b0;
    tick;
    rst = 1'b0; ack8 = 1'b0;
    check("t5_cyc", cyc8, 0);
    check("t5_stb", stb8, 0);
    check("t5_we", we8, 0);
    check("t5_busy", busy8, 0);
    check("t5_adr", adr8, 0);
    req8 = 1'b1; radr8 = 32'h1006;
    tick;
    check("t5_restart_stb", stb8, 1);
    check("t5_restart_adr", adr8, 32'h1004);
    beats8(32'h1004, 0, 8);
    check("t5_cyc_end", cyc8, 0);
    req8 = 1'b0;
    tick;
    tick;
    check("t5_busy_idle", busy8, 0);
    check("t5_we_count", we_cnt8 - wc, 11);
    check("t5_q_empty", exp8_q.size(), 0);
    check("t5_err_count", err_cnt8, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
